// File: rtl/data_mem_hs.sv
// Data memory behind a valid/ready request/response handshake with a programmable access latency.
// Byte/half/word loads and stores, zero/sign extension, and fault reporting for misaligned or out-of-range accesses.
`ifndef DATA_BASE_ADDRESS
`define DATA_BASE_ADDRESS 32'h0000_0000
`endif
`ifndef MEM_BYTE
`define MEM_BYTE 2'b00
`endif
`ifndef MEM_HALF
`define MEM_HALF 2'b01
`endif
`ifndef MEM_WORD
`define MEM_WORD 2'b10
`endif

module data_mem_hs #(
  parameter int unsigned DEPTH     = 1024,
  parameter logic [31:0] BASE_ADDR = `DATA_BASE_ADDRESS,
  parameter int unsigned LATENCY   = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_op,
  input  logic        req_ext,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_fault
);
  localparam int          AW   = $clog2(DEPTH);
  localparam logic [32:0] SPAN = 33'(4 * DEPTH);
  localparam logic [1:0]  OP_B = `MEM_BYTE;
  localparam logic [1:0]  OP_H = `MEM_HALF;
  localparam logic [1:0]  OP_W = `MEM_WORD;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  logic [1:0]    state;
  logic [3:0]    cnt;
  logic          a_we, a_ext;
  logic [1:0]    a_op;
  logic [31:0]   a_addr, a_wdata;
  logic [31:0]   mem [DEPTH];

  logic [31:0]   off;
  logic [AW-1:0] idx;
  logic [1:0]    lane;
  logic          fault, done;
  logic [31:0]   rword, wword, ldata;
  logic [7:0]    byte_v;
  logic [15:0]   half_v;

  // Everything below works off the latched request, so inputs may change freely after accept.
  assign off   = a_addr - BASE_ADDR;
  assign idx   = off[AW+1:2];
  assign lane  = off[1:0];
  assign done  = (state == BUSY) && (cnt == 4'd0);
  assign rword = mem[idx];

  always_comb begin
    fault = ({1'b0, off} >= SPAN);
    case (a_op)
      OP_B:    fault = fault;
      OP_H:    fault = fault | lane[0];
      OP_W:    fault = fault | (lane != 2'd0);
      default: fault = 1'b1;
    endcase
  end

  // Per-byte merge for read-modify-write stores.
  for (genvar b = 0; b < 4; b++) begin : g_lane
    localparam logic [1:0] LB = 2'(b);
    logic       sel;
    logic [7:0] src;
    always_comb begin
      sel = 1'b1;
      src = a_wdata[8*b +: 8];
      case (a_op)
        OP_B: begin
          sel = (lane == LB);
          src = a_wdata[7:0];
        end
        OP_H: begin
          sel = (lane[1] == LB[1]);
          src = LB[0] ? a_wdata[15:8] : a_wdata[7:0];
        end
        default: ;
      endcase
    end
    assign wword[8*b +: 8] = sel ? src : rword[8*b +: 8];
  end

  always_comb begin
    byte_v = 8'(rword >> {lane, 3'b000});
    half_v = lane[1] ? rword[31:16] : rword[15:0];
    case (a_op)
      OP_B:    ldata = {{24{a_ext & byte_v[7]}}, byte_v};
      OP_H:    ldata = {{16{a_ext & half_v[15]}}, half_v};
      default: ldata = rword;
    endcase
  end

  always_ff @(posedge clk) begin
    if (done && a_we && !fault) mem[idx] <= wword;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= 4'd0;
      a_we       <= 1'b0;
      a_ext      <= 1'b0;
      a_op       <= 2'd0;
      a_addr     <= 32'd0;
      a_wdata    <= 32'd0;
      resp_rdata <= 32'd0;
      resp_fault <= 1'b0;
    end else begin
      case (state)
        IDLE: if (req_valid) begin
          a_we    <= req_we;
          a_op    <= req_op;
          a_ext   <= req_ext;
          a_addr  <= req_addr;
          a_wdata <= req_wdata;
          cnt     <= 4'(LATENCY - 1);
          state   <= BUSY;
        end
        BUSY: if (cnt == 4'd0) begin
          resp_rdata <= (fault || a_we) ? 32'd0 : ldata;
          resp_fault <= fault;
          state      <= RESP;
        end else begin
          cnt <= cnt - 4'd1;
        end
        RESP: if (resp_ready) begin
          resp_rdata <= 32'd0;
          resp_fault <= 1'b0;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign req_ready  = (state == IDLE);
  assign resp_valid = (state == RESP);
endmodule

// File: tb/tb_data_mem_hs.sv
// Bench for data_mem_hs: three instances (latency 2, 1, 4) checked every cycle against a transaction-level model,
// plus directed literal expectations.
module tb_data_mem_hs;
  localparam int          N     = 3;
  localparam int          DEPTH = 64;
  localparam logic [31:0] BASE  = 32'h0000_1000;
  localparam int          LATS [N] = '{2, 1, 4};
  localparam logic [1:0]  B = 2'b00, H = 2'b01, W = 2'b10;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [N-1:0]       req_valid, req_ready, req_we, req_ext, resp_valid, resp_ready, resp_fault;
  logic [N-1:0][1:0]  req_op;
  logic [N-1:0][31:0] req_addr, req_wdata, resp_rdata;

  always #5 clk = ~clk;

  for (genvar g = 0; g < N; g++) begin : g_dut
    data_mem_hs #(.DEPTH(DEPTH), .BASE_ADDR(BASE), .LATENCY(LATS[g])) u_dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid[g]), .req_ready(req_ready[g]), .req_we(req_we[g]),
      .req_op(req_op[g]), .req_ext(req_ext[g]), .req_addr(req_addr[g]), .req_wdata(req_wdata[g]),
      .resp_valid(resp_valid[g]), .resp_ready(resp_ready[g]),
      .resp_rdata(resp_rdata[g]), .resp_fault(resp_fault[g])
    );
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Transaction model: one outstanding request per instance, response due LATS[k] edges after accept.
  logic [N-1:0]       inflight = '0;
  int                 age [N];
  logic [N-1:0]       m_we, m_ext, m_fault;
  logic [N-1:0][1:0]  m_op;
  logic [N-1:0][31:0] m_addr, m_wdata, m_rdata;
  bit   [31:0]        mm [N*DEPTH];

  task automatic access(input int k);
    logic [31:0] off, mask, v;
    int sh, sz, key;
    logic flt;
    off = m_addr[k] - BASE;
    flt = (off >= 32'(4*DEPTH)) || (m_op[k] == 2'b11) ||
          (m_op[k] == H && off[0]) || (m_op[k] == W && off[1:0] != 2'd0);
    sz  = (m_op[k] == B) ? 8 : (m_op[k] == H) ? 16 : 32;
    mask = (sz == 32) ? 32'hFFFF_FFFF : ((32'd1 << sz) - 32'd1);
    sh  = int'(off[1:0]) * 8;
    v   = 32'd0;
    if (!flt) begin
      key = k*DEPTH + int'(off[31:2]);
      if (m_we[k]) begin
        mm[key] <= (mm[key] & ~(mask << sh)) | ((m_wdata[k] & mask) << sh);
      end else begin
        v = (mm[key] >> sh) & mask;
        if (m_ext[k] && sz < 32 && v[sz-1]) v = v | ~mask;
      end
    end
    m_rdata[k] <= v;
    m_fault[k] <= flt;
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      inflight <= '0;
    end else begin
      for (int k = 0; k < N; k++) begin
        if (inflight[k] && age[k] >= LATS[k]) begin
          if (resp_ready[k]) inflight[k] <= 1'b0;
        end else if (inflight[k]) begin
          age[k] <= age[k] + 1;
          if (age[k] + 1 == LATS[k]) access(k);
        end else if (req_valid[k]) begin
          m_we[k]    <= req_we[k];
          m_op[k]    <= req_op[k];
          m_ext[k]   <= req_ext[k];
          m_addr[k]  <= req_addr[k];
          m_wdata[k] <= req_wdata[k];
          age[k]     <= 0;
          inflight[k] <= 1'b1;
        end
      end
    end
  end

  always @(negedge clk) begin
    for (int k = 0; k < N; k++) begin
      logic ev;
      ev = inflight[k] && (age[k] >= LATS[k]);
      chk($sformatf("req_ready[%0d]", k), 32'(req_ready[k]), 32'(!inflight[k]));
      chk($sformatf("resp_valid[%0d]", k), 32'(resp_valid[k]), 32'(ev));
      chk($sformatf("resp_rdata[%0d]", k), resp_rdata[k], ev ? m_rdata[k] : 32'd0);
      chk($sformatf("resp_fault[%0d]", k), 32'(resp_fault[k]), ev ? 32'(m_fault[k]) : 32'd0);
    end
  end

  task automatic wait_ready(input int k);
    int n = 0;
    do begin @(negedge clk); n++; end while (!req_ready[k] && n < 50);
    chk("accept_timeout", 32'(n < 50), 32'd1);
  endtask

  task automatic wait_resp(input int k);
    int n = 0;
    do begin @(negedge clk); n++; end while (!resp_valid[k] && n < 50);
    chk("resp_timeout", 32'(n < 50), 32'd1);
  endtask

  task automatic drive(input int k, input logic we, input logic [1:0] op, input logic ext,
                       input logic [31:0] addr, input logic [31:0] wdata);
    req_valid[k] = 1'b1; req_we[k] = we; req_op[k] = op; req_ext[k] = ext;
    req_addr[k] = addr; req_wdata[k] = wdata;
  endtask

  task automatic txn(input int k, input logic we, input logic [1:0] op, input logic ext,
                     input logic [31:0] addr, input logic [31:0] wdata,
                     output logic [31:0] rd, output logic flt);
    drive(k, we, op, ext, addr, wdata);
    wait_ready(k);
    @(posedge clk); #2;
    // Scramble request fields after accept; the latched request must be used.
    req_valid[k] = 1'b0; req_we[k] = 1'($urandom); req_op[k] = 2'($urandom);
    req_addr[k] = $urandom; req_wdata[k] = $urandom;
    wait_resp(k);
    rd = resp_rdata[k]; flt = resp_fault[k];
    @(posedge clk); #2;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd, held;
    logic f;
    req_valid = '0; req_we = '0; req_ext = '0; req_op = '0;
    req_addr = '0; req_wdata = '0; resp_ready = '1;
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;

    // Word store then load
    txn(0, 1, W, 0, BASE+8, 32'hDEADBEEF, rd, f); chk("st_w_fault", 32'(f), 0);
    txn(0, 0, W, 0, BASE+8, 0, rd, f);            chk("ld_w", rd, 32'hDEADBEEF);

    // Byte store, signed/unsigned byte loads
    txn(0, 1, B, 0, BASE+9, 32'h0000_0080, rd, f);
    txn(0, 0, B, 1, BASE+9, 0, rd, f);            chk("ld_b_s", rd, 32'hFFFFFF80);
    txn(0, 0, B, 0, BASE+9, 0, rd, f);            chk("ld_b_u", rd, 32'h00000080);
    txn(0, 0, W, 0, BASE+8, 0, rd, f);            chk("ld_w_merge", rd, 32'hDEAD80EF);

    // Half load, misaligned half store
    txn(0, 0, H, 1, BASE+10, 0, rd, f);           chk("ld_h_s", rd, 32'hFFFFDEAD);
    txn(0, 1, H, 0, BASE+11, 32'h1234, rd, f);    chk("st_h_mis_fault", 32'(f), 1);
    txn(0, 0, W, 0, BASE+8, 0, rd, f);            chk("ld_w_nochange", rd, 32'hDEAD80EF);

    // Range faults and undefined op
    txn(0, 0, W, 0, BASE+4*DEPTH, 0, rd, f);      chk("oor_hi_fault", 32'(f), 1); chk("oor_hi_rd", rd, 0);
    txn(0, 0, W, 0, BASE-4, 0, rd, f);            chk("oor_lo_fault", 32'(f), 1); chk("oor_lo_rd", rd, 0);
    txn(0, 0, 2'b11, 0, BASE+8, 0, rd, f);        chk("op11_fault", 32'(f), 1);
    txn(0, 0, W, 0, BASE+8, 0, rd, f);            chk("legal_fault", 32'(f), 0); chk("legal_rd", rd, 32'hDEAD80EF);

    // Back-pressure: response held, pending request waits for the handshake
    resp_ready[0] = 1'b0;
    drive(0, 0, W, 0, BASE+8, 0);
    wait_ready(0);
    @(posedge clk); #2;
    drive(0, 0, B, 0, BASE+9, 0);
    wait_resp(0);
    held = resp_rdata[0];
    chk("hold_first", held, 32'hDEAD80EF);
    repeat (5) begin
      @(negedge clk);
      chk("hold_rdata", resp_rdata[0], held);
      chk("hold_valid", 32'(resp_valid[0]), 1);
      chk("hold_ready", 32'(req_ready[0]), 0);
    end
    @(posedge clk); #2 resp_ready[0] = 1'b1;
    wait_ready(0);
    @(posedge clk); #2 req_valid[0] = 1'b0;
    wait_resp(0);
    chk("after_hs_ld_b", resp_rdata[0], 32'h00000080);
    @(posedge clk); #2;

    // Mid-cycle reset while a response is being held
    resp_ready[0] = 1'b0;
    drive(0, 0, W, 0, BASE+8, 0);
    wait_ready(0);
    @(posedge clk); #2 req_valid[0] = 1'b0;
    wait_resp(0);
    #2 rst = 1'b1;
    #1;
    chk("rst_ready", 32'(req_ready[0]), 1);
    chk("rst_valid", 32'(resp_valid[0]), 0);
    chk("rst_rdata", resp_rdata[0], 0);
    chk("rst_fault", 32'(resp_fault[0]), 0);
    @(posedge clk); #2 rst = 1'b0; resp_ready[0] = 1'b1;

    // Reset one cycle after accepting a store: the store must never land
    txn(0, 1, W, 0, BASE+0, 32'hAAAA5555, rd, f);
    drive(0, 1, W, 0, BASE+0, 32'h12345678);
    wait_ready(0);
    @(posedge clk); #2 req_valid[0] = 1'b0;
    @(posedge clk); #3 rst = 1'b1;
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    txn(0, 0, W, 0, BASE+0, 0, rd, f);            chk("rst_store_dropped", rd, 32'hAAAA5555);

    // Latency 1 and 4 instances
    for (int k = 1; k < N; k++) begin
      txn(k, 1, W, 0, BASE+8, 32'hDEADBEEF, rd, f); chk($sformatf("lat%0d_st_fault", LATS[k]), 32'(f), 0);
      txn(k, 0, W, 0, BASE+8, 0, rd, f);            chk($sformatf("lat%0d_ld_w", LATS[k]), rd, 32'hDEADBEEF);
    end

    repeat (2) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
